// File: rtl/fetch_stage.sv
// Fetch stage: owns the fetch PC, issues one imem request at a time
// and presents pc/instruction/valid/exception beats to the F/D registers.
module fetch_stage #(
  parameter int                   WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = 32'h0000_1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 imem_req_valid,
  output logic [WORD_SIZE-1:0] imem_req_addr,
  input  logic                 imem_req_ready,
  input  logic                 imem_resp_valid,
  input  logic [WORD_SIZE-1:0] imem_resp_data,
  output logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] instruction,
  output logic                 valid,
  output logic                 exception
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_SIZE-1:0] out_pc_q, out_pc_d;
  logic [WORD_SIZE-1:0] out_instr_q, out_instr_d;
  logic                 out_exc_q, out_exc_d;
  logic                 valid_q, valid_d;
  logic                 kill_q, kill_d;
  logic                 misaligned;

  assign misaligned = |redirect_pc[1:0];

  assign imem_req_valid = (state_q == S_REQ) && !redirect;
  assign imem_req_addr  = fetch_pc_q;

  assign pc          = out_pc_q;
  assign instruction = out_instr_q;
  assign valid       = valid_q;
  assign exception   = out_exc_q;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_exc_d   = out_exc_q;
    valid_d     = valid_q;
    kill_d      = kill_q;
    if (redirect) begin
      if (misaligned) begin
        out_pc_d    = redirect_pc;
        out_instr_d = '0;
        out_exc_d   = 1'b1;
        valid_d     = 1'b1;
        kill_d      = 1'b0;
        state_d     = S_OUT;
      end else begin
        fetch_pc_d = redirect_pc;
        valid_d    = 1'b0;
        out_exc_d  = 1'b0;
        // An in-flight response must be swallowed once it arrives.
        if (state_q == S_WAIT && !imem_resp_valid) begin
          kill_d  = 1'b1;
          state_d = S_WAIT;
        end else begin
          kill_d  = 1'b0;
          state_d = S_REQ;
        end
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem_req_ready) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              out_pc_d    = fetch_pc_q;
              out_instr_d = imem_resp_data;
              out_exc_d   = 1'b0;
              valid_d     = 1'b1;
              fetch_pc_d  = fetch_pc_q + WORD_SIZE'(4);
              state_d     = S_OUT;
            end
          end
        end
        S_OUT: begin
          if (!stall) begin
            valid_d   = 1'b0;
            out_exc_d = 1'b0;
            state_d   = out_exc_q ? S_HALT : S_REQ;
          end
        end
        default: begin
          state_d = S_HALT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_REQ;
      fetch_pc_q  <= RESET_PC;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_exc_q   <= 1'b0;
      valid_q     <= 1'b0;
      kill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_exc_q   <= out_exc_d;
      valid_q     <= valid_d;
      kill_q      <= kill_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences and
// randomized traffic against a transaction-level reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [31:0] imem_req_addr, imem_resp_data;
  logic [31:0] pc, instruction;
  logic        valid, exception;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .pc              (pc),
    .instruction     (instruction),
    .valid           (valid),
    .exception       (exception)
  );

  typedef struct {
    logic        rst, st, rd, rdy, ck, cx;
    logic [31:0] rpc;
    int          lat;
    logic        ev, eexc, erq;
    logic [31:0] epc, eins, eaddr;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int mcnt   = 0;
  logic [31:0] maddr = 0;
  logic spur_en = 1'b0;

  // reference model: beat register, outstanding-request flags, halt
  logic [31:0] m_fpc, m_pc, m_ins;
  logic        m_v, m_exc, m_wait, m_drop, m_halt;

  vec_t tbl[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fpc = 32'h0000_1000; m_pc = 0; m_ins = 0;
    m_v = 0; m_exc = 0; m_wait = 0; m_drop = 0; m_halt = 0;
  endtask

  function automatic vec_t mk(logic st, logic rd, logic [31:0] rpc,
                              int lat, logic ev, logic exc,
                              logic [31:0] epc, logic [31:0] eins,
                              logic erq, logic [31:0] eaddr);
    vec_t v;
    v.rst = 0; v.st = st; v.rd = rd; v.rpc = rpc; v.rdy = 1;
    v.lat = lat; v.ck = 1; v.cx = ev;
    v.ev = ev; v.eexc = exc; v.epc = epc; v.eins = eins;
    v.erq = erq; v.eaddr = eaddr;
    return v;
  endfunction

  function automatic vec_t idle(logic erq, logic [31:0] eaddr);
    return mk(0, 0, 0, 1, 0, 0, 0, 0, erq, eaddr);
  endfunction

  function automatic vec_t beat(logic st, logic [31:0] p);
    return mk(st, 0, 0, 1, 1, 0, p, mem(p), 0, 0);
  endfunction

  function automatic vec_t redir(logic [31:0] t);
    return mk(0, 1, t, 1, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic cycle(input vec_t v);
    logic        rq_exp, rv;
    logic [31:0] rdat;
    if (mcnt == 1) begin
      imem_resp_valid = 1; imem_resp_data = mem(maddr);
    end else if (spur_en && mcnt == 0 && !m_wait
                 && $urandom_range(0, 3) == 0) begin
      imem_resp_valid = 1; imem_resp_data = $urandom;
    end else begin
      imem_resp_valid = 0; imem_resp_data = $urandom;
    end
    if (mcnt > 0) mcnt--;
    reset = v.rst; stall = v.st; redirect = v.rd;
    redirect_pc = v.rpc; imem_req_ready = v.rdy;
    #1;
    rq_exp = !m_wait && !m_v && !m_halt && !v.rd;
    chk("model_valid", 32'(valid), 32'(m_v));
    chk("model_req_valid", 32'(imem_req_valid), 32'(rq_exp));
    if (rq_exp) chk("model_req_addr", imem_req_addr, m_fpc);
    if (m_v) begin
      chk("model_pc", pc, m_pc);
      chk("model_instr", instruction, m_ins);
      chk("model_exc", 32'(exception), 32'(m_exc));
    end
    if (v.ck) begin
      chk("vec_valid", 32'(valid), 32'(v.ev));
      chk("vec_req_valid", 32'(imem_req_valid), 32'(v.erq));
      if (v.cx) chk("vec_exc", 32'(exception), 32'(v.eexc));
      if (v.ev) begin
        chk("vec_pc", pc, v.epc);
        chk("vec_instr", instruction, v.eins);
      end
      if (v.erq) chk("vec_req_addr", imem_req_addr, v.eaddr);
    end
    if (imem_req_valid && v.rdy) begin
      mcnt = v.lat; maddr = imem_req_addr;
    end
    if (v.rst) mcnt = 0;
    rv = imem_resp_valid; rdat = imem_resp_data;
    if (v.rst) model_reset();
    else if (v.rd) begin
      m_halt = 0;
      if (v.rpc[1:0] != 2'b00) begin
        m_v = 1; m_pc = v.rpc; m_ins = 0; m_exc = 1;
        m_wait = 0; m_drop = 0;
      end else begin
        m_fpc  = v.rpc; m_v = 0;
        m_drop = m_wait && !rv;
        m_wait = m_wait && !rv;
      end
    end else if (m_wait) begin
      if (rv) begin
        m_wait = 0;
        if (m_drop) m_drop = 0;
        else begin
          m_v = 1; m_pc = m_fpc; m_ins = rdat; m_exc = 0;
          m_fpc = m_fpc + 32'd4;
        end
      end
    end else if (m_v) begin
      if (!v.st) begin m_v = 0; m_halt = m_exc; end
    end else if (!m_halt && v.rdy) m_wait = 1;
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    reset = 1; stall = 0; redirect = 0; redirect_pc = 0;
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
    @(negedge clk); @(negedge clk);
    model_reset();
    #1;
    chk("reset_valid", 32'(valid), 0);
    chk("reset_exc", 32'(exception), 0);
    chk("reset_pc", pc, 0);
    chk("reset_instr", instruction, 0);

    // back-to-back fetch, 4-cycle stall, misaligned halt, wrap
    tbl.push_back(idle(1, 32'h1000));
    tbl.push_back(idle(0, 0));
    tbl.push_back(beat(0, 32'h1000));
    tbl.push_back(idle(1, 32'h1004));
    tbl.push_back(idle(0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(beat(1, 32'h1004));
    tbl.push_back(beat(0, 32'h1004));
    tbl.push_back(idle(1, 32'h1008));
    tbl.push_back(idle(0, 0));
    tbl.push_back(beat(0, 32'h1008));
    tbl.push_back(redir(32'h2002));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'h2002, 0, 0, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(redir(32'h3000));
    tbl.push_back(idle(1, 32'h3000));
    tbl.push_back(idle(0, 0));
    tbl.push_back(beat(0, 32'h3000));
    tbl.push_back(redir(32'hFFFF_FFFC));
    tbl.push_back(idle(1, 32'hFFFF_FFFC));
    tbl.push_back(idle(0, 0));
    tbl.push_back(beat(0, 32'hFFFF_FFFC));
    tbl.push_back(idle(1, 32'h0000_0000));
    tbl.push_back(idle(0, 0));
    tbl.push_back(beat(0, 32'h0000_0000));
    for (int i = 0; i < tbl.size(); i++) cycle(tbl[i]);

    // redirect while waiting, stale response 2 cycles later
    v = idle(0, 0); v.rst = 1; v.ck = 0; cycle(v);
    cycle(idle(1, 32'h1000));
    cycle(idle(0, 0));
    cycle(beat(0, 32'h1000));
    v = idle(1, 32'h1004); v.lat = 2; cycle(v);
    cycle(redir(32'h2000));
    cycle(idle(0, 0));
    cycle(idle(1, 32'h2000));
    cycle(idle(0, 0));
    cycle(beat(0, 32'h2000));

    // reset over a stalled beat
    cycle(idle(1, 32'h2004));
    cycle(idle(0, 0));
    cycle(beat(1, 32'h2004));
    v = beat(1, 32'h2004); v.rst = 1; cycle(v);
    v = idle(1, 32'h1000); v.cx = 1; v.eexc = 0; cycle(v);
    cycle(idle(0, 0));
    cycle(beat(0, 32'h1000));

    // randomized traffic against the model
    spur_en = 1'b1;
    for (int n = 0; n < 600; n++) begin
      v = idle(0, 0);
      v.ck  = 0;
      v.rst = ($urandom_range(0, 59) == 0);
      v.st  = ($urandom_range(0, 2) == 0);
      v.rd  = ($urandom_range(0, 7) == 0);
      v.rdy = ($urandom_range(0, 3) != 0);
      v.lat = $urandom_range(1, 3);
      v.rpc = $urandom;
      if ($urandom_range(0, 3) != 0) v.rpc[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) v.rpc = 32'hFFFF_FFFC;
      cycle(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Producer side of the fetch/decode pipeline interface.
- Owns the fetch PC and issues one instruction-memory request at a time.
- Delivers pc/instruction/valid/exception beats to the F/D pipeline registers and honours their stall.
- Applies branch redirects and raises a misaligned-fetch exception without touching memory.

Parameters:
WORD_SIZE, 32, width of PC, addresses and instruction words (codebase `WORD_SIZE).
RESET_PC, 32'h0000_1000, fetch address loaded on reset.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  downstream cannot accept; current beat must be held.
redirect  input  1  branch/jump resolved taken; restart fetch at redirect_pc.
redirect_pc  input  WORD_SIZE  redirect target.
imem_req_valid  output  1  request to instruction memory.
imem_req_addr  output  WORD_SIZE  request address (= fetch_pc).
imem_req_ready  input  1  memory accepts request this cycle.
imem_resp_valid  input  1  response data valid (1 cycle pulse).
imem_resp_data  input  WORD_SIZE  fetched instruction.
pc  output  WORD_SIZE  PC of delivered beat.
instruction  output  WORD_SIZE  delivered instruction.
valid  output  1  beat valid.
exception  output  1  beat carries misaligned-fetch exception.

Behaviour:
- Registers:
  - fetch_pc, out_pc, out_instr, out_exc, valid_r, kill flag.
  - States: REQ, WAIT, OUT, HALT.
  - pc, instruction, exception and valid are driven directly from these registers.
- Reset:
  - State REQ, fetch_pc=RESET_PC, valid=0, exception=0, pc=0, instruction=0, kill=0.
  - The instruction memory shares this reset and drops in-flight requests.
  - imem_resp_valid outside WAIT is ignored.
- A beat is consumed on a rising edge with valid=1 and stall=0.
- Misaligned target:
  - Condition: redirect_pc[1:0] != 0.
  - Action: out_pc←redirect_pc, out_instr←0, out_exc←1, valid←1, go to OUT.
  - No memory request is issued.
- Redirect has priority over every other event in every state.
  - Aligned target: fetch_pc←redirect_pc, valid←0.
  - Misaligned target: handled as above.
  - imem_req_valid is forced to 0 in any cycle with redirect=1.
- REQ:
  - imem_req_valid=1, imem_req_addr=fetch_pc.
  - req_ready=1 → WAIT; otherwise stay in REQ.
- WAIT:
  - imem_req_valid=0.
  - On resp_valid with kill=1: discard the response, kill←0, go to REQ (fetch_pc already holds the target).
  - On resp_valid with kill=0: out_pc←fetch_pc, out_instr←resp_data, out_exc←0, valid←1, fetch_pc←fetch_pc+4 (modulo 2^WORD_SIZE, wraps to 0), go to OUT.
  - Redirect without resp_valid: kill←1, stay in WAIT.
  - Redirect with resp_valid in the same cycle: response discarded, go to REQ (or OUT if misaligned); kill stays 0.
- OUT:
  - stall=1: hold all outputs unchanged.
  - stall=0, beat consumed, out_exc=0: valid←0 → REQ.
  - stall=0, beat consumed, out_exc=1: valid←0 → HALT.
  - imem_req_valid=0 in OUT.
- HALT:
  - valid=0, no requests.
  - Leaves only on redirect.
- Latency and throughput:
  - With a memory response exactly 1 cycle after the request is accepted, the first beat is visible 2 cycles after REQ.
  - Throughput is one beat per 3 cycles.
- Simultaneous stall=0 and redirect in OUT: the redirect wins and the beat is dropped (valid←0).
- Reset asserted in any state overrides everything, including a pending response or a held beat.

Test Plan:
1. Reset, memory with 1-cycle latency returning addr^32'hA5A5_0000: beats pc=0x1000,0x1004,0x1008 with matching instructions, exception=0, one beat per 3 cycles.
2. Hold stall=1 for 4 cycles while valid=1 at pc=0x1004: pc, instruction and valid stay constant; after release the next request is addr 0x1008.
3. Redirect to 0x2000 during WAIT for 0x1004, response arriving 2 cycles later: that response is discarded, the next request is 0x2000, and the next beat has pc=0x2000.
4. Redirect to 0x2002: next cycle valid=1, exception=1, pc=0x2002, instruction=0, no imem_req_valid. After consumption the block sits in HALT with valid=0 until a redirect to 0x3000 resumes fetch.
5. Redirect to 32'hFFFF_FFFC: beat pc=FFFF_FFFC, then next request address 0x0000_0000.
6. Assert reset while a beat is held under stall: next cycle valid=0, exception=0; fetch restarts at 0x1000.
